// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder.
// Optional feature macro: MEM_RESPONDER_ALIGN_CHECK_EN (adds the misalign output).
package mem_pkg;

  localparam int unsigned MAX_WAIT = 15;

  typedef enum logic [1:0] {MR_IDLE, MR_ACCESS, MR_RESP} mrState;
  typedef enum logic [1:0] {REQ_FETCH, REQ_LOAD, REQ_STORE} reqKind;

  // True when an access of popcount(strobe) bytes starting at byte offset off runs past the word.
  function automatic logic crosses_word(input logic [1:0] off, input logic [3:0] strobe);
    logic [2:0] nbytes;
    nbytes = 3'(strobe[0]) + 3'(strobe[1]) + 3'(strobe[2]) + 3'(strobe[3]);
    return (3'(off) + nbytes) > 3'd4;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/response bus between the request unit and the memory responder.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imemRen;
  logic [ADDR_W-1:0] imemaddr;
  logic              dmmRen;
  logic              dmmWen;
  logic [ADDR_W-1:0] dmmaddr;
  logic [DATA_W-1:0] dmmstore;
  logic [3:0]        dmmstrobe;
  logic              i_ready;
  logic              d_ready;
  logic [DATA_W-1:0] imemload;
  logic [DATA_W-1:0] dmmload;

  // Request unit side.
  modport master (
    output imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, dmmstrobe,
    input  i_ready, d_ready, imemload, dmmload
  );

  // Memory responder side.
  modport slave (
    input  imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, dmmstrobe,
    output i_ready, d_ready, imemload, dmmload
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Fixed-priority request select (store > load > fetch) plus the latch enable for the responder FSM.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              idle,
  input  logic              imem_req,
  input  logic              dmm_rreq,
  input  logic              dmm_wreq,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W-1:0] dmm_addr,
  output logic              latch_en_c,
  output reqKind            kind_c,
  output logic [ADDR_W-1:0] addr_c
);

  // Data accesses win so the in-flight instruction completes before the next fetch.
  always_comb begin
    latch_en_c = idle && (imem_req || dmm_rreq || dmm_wreq);
    kind_c     = REQ_FETCH;
    addr_c     = imem_addr;
    if (dmm_wreq) begin
      kind_c = REQ_STORE;
      addr_c = dmm_addr;
    end else if (dmm_rreq) begin
      kind_c = REQ_LOAD;
      addr_c = dmm_addr;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Serializes fetch/load/store requests onto one single-port synchronous RAM with wait states.
// Optional feature macro: MEM_RESPONDER_ALIGN_CHECK_EN (misalign detection and RAM bypass).
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  mem_responder_if.slave    bus,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [3:0]        ram_be,
  output logic [DATA_W-1:0] ram_wdata
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES);

  mrState            state;
  reqKind            kind_q;
  logic [3:0]        cnt;
  logic              latch_en_c;
  reqKind            kind_c;
  logic [ADDR_W-1:0] addr_c;

  mem_req_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .idle       (state == MR_IDLE),
    .imem_req   (bus.imemRen),
    .dmm_rreq   (bus.dmmRen),
    .dmm_wreq   (bus.dmmWen),
    .imem_addr  (bus.imemaddr),
    .dmm_addr   (bus.dmmaddr),
    .latch_en_c (latch_en_c),
    .kind_c     (kind_c),
    .addr_c     (addr_c)
  );

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic fault_c;

  // Fetches must be word aligned; data accesses must stay inside one word.
  always_comb begin
    fault_c = 1'b0;
    if (kind_c == REQ_FETCH) fault_c = (addr_c[1:0] != 2'b00);
    else                     fault_c = crosses_word(addr_c[1:0], bus.dmmstrobe);
  end
`endif

  // Responder FSM: latch the winning request, run the RAM access, emit a one-cycle ready.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= MR_IDLE;
      kind_q       <= REQ_FETCH;
      cnt          <= 4'd0;
      ram_addr     <= '0;
      ram_ren      <= 1'b0;
      ram_wen      <= 1'b0;
      ram_be       <= 4'b0000;
      ram_wdata    <= '0;
      bus.i_ready  <= 1'b0;
      bus.d_ready  <= 1'b0;
      bus.imemload <= '0;
      bus.dmmload  <= '0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      misalign     <= 1'b0;
`endif
    end else begin
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      misalign    <= 1'b0;
`endif
      case (state)
        MR_IDLE: begin
          if (latch_en_c) begin
            kind_q   <= kind_c;
            cnt      <= CNT_INIT;
            ram_addr <= addr_c & ~ADDR_W'(3);
            ram_be   <= (kind_c == REQ_STORE) ? bus.dmmstrobe : 4'b1111;
            if (kind_c == REQ_STORE) ram_wdata <= bus.dmmstore;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
            if (fault_c) begin
              state       <= MR_RESP;
              bus.i_ready <= (kind_c == REQ_FETCH);
              bus.d_ready <= (kind_c != REQ_FETCH);
              misalign    <= 1'b1;
            end else
`endif
            begin
              state   <= MR_ACCESS;
              ram_ren <= (kind_c != REQ_STORE);
              ram_wen <= (kind_c == REQ_STORE) && (CNT_INIT == 4'd0);
            end
          end
        end
        MR_ACCESS: begin
          if (cnt == 4'd0) begin
            state       <= MR_RESP;
            ram_ren     <= 1'b0;
            ram_wen     <= 1'b0;
            bus.i_ready <= (kind_q == REQ_FETCH);
            bus.d_ready <= (kind_q != REQ_FETCH);
            if (kind_q == REQ_FETCH)     bus.imemload <= ram_rdata;
            else if (kind_q == REQ_LOAD) bus.dmmload  <= ram_rdata;
          end else begin
            cnt     <= cnt - 4'd1;
            // Store strobe lands only in the last access cycle so each store writes once.
            ram_wen <= (kind_q == REQ_STORE) && (cnt == 4'd1);
          end
        end
        MR_RESP: state <= MR_IDLE;
        default: state <= MR_IDLE;
      endcase
    end
  end

endmodule
